// File: rtl/phase_speed_estimator.sv
// Phase-to-speed estimator: averages the phase (or its wrapped delta) over a
// 2^N_LOG-sample window, scales the average and presents it with a handshake.
module phase_speed_estimator #(
  parameter int PHASE_W     = 19,
  parameter int FRAC        = 10,
  parameter int N_LOG       = 6,
  parameter int SPEED_W     = 16,
  parameter int SCALE_W     = 15,
  parameter int SCALE       = 20450,
  parameter int SCALE_SHIFT = 14,
  parameter int PI_Q        = 3217
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sample,
  input  logic [PHASE_W-1:0] phase,
  input  logic               mode,
  input  logic               clear,
  output logic [SPEED_W-1:0] speed,
  output logic               speed_valid,
  input  logic               speed_ready,
  output logic               sat,
  output logic               overrun
);

  localparam int X_W    = PHASE_W + 1;
  localparam int SUM_W  = PHASE_W + N_LOG + 1;
  localparam int PROD_W = X_W + SCALE_W + 1;

  localparam logic signed [X_W-1:0]     PI_X     = X_W'(PI_Q);
  localparam logic signed [X_W-1:0]     TWO_PI_X = X_W'(2 * PI_Q);
  localparam logic signed [SCALE_W:0]   SCALE_S  = (SCALE_W + 1)'(SCALE);
  localparam logic signed [PROD_W-1:0]  SPD_MAX  = PROD_W'((2 ** (SPEED_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0]  SPD_MIN  = ~SPD_MAX;

  logic                      mode_q;
  logic signed [PHASE_W-1:0] prev;
  logic                      have_prev;
  logic [N_LOG-1:0]          count;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   sum_next;
  logic signed [SUM_W-1:0]   win_sum;
  logic                      win_valid;
  logic signed [X_W-1:0]     avg;
  logic                      avg_valid;
  logic signed [PROD_W-1:0]  prod;
  logic                      prod_valid;
  logic signed [PROD_W-1:0]  prod_shift;
  logic signed [X_W-1:0]     diff;
  logic signed [X_W-1:0]     x;
  logic signed [SPEED_W-1:0] spd_sat;
  logic                      sat_next;
  logic                      close;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    diff = X_W'($signed(phase)) - X_W'(prev);
    x    = '0;
    if (!mode_q) begin
      x = X_W'($signed(phase));
    end else if (have_prev) begin
      x = diff;
      if (diff > PI_X)       x = diff - TWO_PI_X;
      else if (diff < -PI_X) x = diff + TWO_PI_X;
    end
    sum_next   = sum + SUM_W'(x);
    close      = sample && (count == '1);
    prod_shift = prod >>> SCALE_SHIFT;
    sat_next   = 1'b0;
    spd_sat    = SPEED_W'(prod_shift);
    if (prod_shift > SPD_MAX) begin
      spd_sat  = SPEED_W'(SPD_MAX);
      sat_next = 1'b1;
    end else if (prod_shift < SPD_MIN) begin
      spd_sat  = SPEED_W'(SPD_MIN);
      sat_next = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q      <= mode;
      prev        <= '0;
      have_prev   <= 1'b0;
      count       <= '0;
      sum         <= '0;
      win_sum     <= '0;
      win_valid   <= 1'b0;
      avg         <= '0;
      avg_valid   <= 1'b0;
      prod        <= '0;
      prod_valid  <= 1'b0;
      speed       <= '0;
      sat         <= 1'b0;
      speed_valid <= 1'b0;
      overrun     <= 1'b0;
    end else if (clear) begin
      // Clear beats sample and every pipeline load; speed/sat keep their value.
      mode_q      <= mode;
      prev        <= '0;
      have_prev   <= 1'b0;
      count       <= '0;
      sum         <= '0;
      win_valid   <= 1'b0;
      avg_valid   <= 1'b0;
      prod_valid  <= 1'b0;
      speed_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (sample) begin
        prev      <= $signed(phase);
        have_prev <= 1'b1;
        count     <= count + 1'b1;
        sum       <= close ? '0 : sum_next;
      end

      // Window sum -> average -> scaled product -> saturated speed.
      win_valid <= close;
      if (close) win_sum <= sum_next;

      avg_valid <= win_valid;
      if (win_valid) avg <= win_sum[SUM_W-1:N_LOG];

      prod_valid <= avg_valid;
      if (avg_valid) prod <= PROD_W'(avg) * PROD_W'(SCALE_S);

      if (prod_valid) begin
        speed       <= spd_sat;
        sat         <= sat_next;
        speed_valid <= 1'b1;
        overrun     <= speed_valid && !speed_ready;
      end else begin
        overrun <= 1'b0;
        if (speed_ready) speed_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_phase_speed_estimator.sv
// Directed bench for phase_speed_estimator: hand-computed window results,
// result latency, handshake/overrun, clear and reset aborts.
module tb_phase_speed_estimator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sample = 1'b0;
  logic [18:0] phase = '0;
  logic        mode = 1'b0;
  logic        clear = 1'b0;
  logic        speed_ready = 1'b0;
  logic [15:0] speed;
  logic        speed_valid;
  logic        sat;
  logic        overrun;

  int n_cmp   = 0;
  int n_bad   = 0;
  int ovr_cnt = 0;

  phase_speed_estimator dut (
    .clock       (clock),
    .reset       (reset),
    .sample      (sample),
    .phase       (phase),
    .mode        (mode),
    .clear       (clear),
    .speed       (speed),
    .speed_valid (speed_valid),
    .speed_ready (speed_ready),
    .sat         (sat),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle; overrun pulses are tallied here.
  task automatic step();
    @(posedge clock);
    #1;
    if (overrun) ovr_cnt++;
  endtask

  task automatic send(input int p);
    phase  = 19'(p);
    sample = 1'b1;
    step();
    sample = 1'b0;
  endtask

  task automatic send_const(input int p, input int n);
    for (int i = 0; i < n; i++) send(p);
  endtask

  // Called right after the edge that accepted the closing sample.
  task automatic expect_result(input string tag, input longint spd, input longint st,
                               input logic pre);
    check({tag, ".valid_e0"}, speed_valid, pre);
    for (int i = 1; i < 3; i++) begin
      step();
      check($sformatf("%s.valid_e%0d", tag, i), speed_valid, pre);
    end
    step();
    check({tag, ".valid_e3"}, speed_valid, 1);
    check({tag, ".speed"}, $signed(speed), spd);
    check({tag, ".sat"}, sat, st);
  endtask

  task automatic consume(input string tag);
    speed_ready = 1'b1;
    step();
    speed_ready = 1'b0;
    check({tag, ".consumed"}, speed_valid, 0);
  endtask

  task automatic do_clear(input logic m);
    mode  = m;
    clear = 1'b1;
    step();
    clear = 1'b0;
    mode  = ~m;
  endtask

  initial begin
    int  p;
    logic saw_valid;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("rst.speed", $signed(speed), 0);
    check("rst.valid", speed_valid, 0);
    check("rst.sat", sat, 0);
    check("rst.overrun", overrun, 0);

    // Mode 0: constant phase 1024 -> 1024*20450>>14 = 1278.
    send_const(1024, 64);
    expect_result("m0", 1278, 0, 0);
    consume("m0");
    check("m0.hold_speed", $signed(speed), 1278);

    // Saturation on both rails.
    send_const(200000, 64);
    expect_result("sat_pos", 32767, 1, 0);
    consume("sat_pos");
    send_const(-200000, 64);
    expect_result("sat_neg", -32768, 1, 0);
    consume("sat_neg");

    // Two closes without consumption: one overrun, second value wins.
    ovr_cnt = 0;
    send_const(1024, 64);
    expect_result("hs_a", 1278, 0, 0);
    send_const(2048, 32);
    check("hs.hold_valid", speed_valid, 1);
    check("hs.hold_speed", $signed(speed), 1278);
    send_const(2048, 32);
    expect_result("hs_b", 2556, 0, 1);
    check("hs.overrun_count", ovr_cnt, 1);
    consume("hs_b");
    check("hs.after_speed", $signed(speed), 2556);

    // Mode 1 latched by clear; live mode input is then 0 and must be ignored.
    do_clear(1'b1);
    for (int k = 0; k < 64; k++) send(100 * k);
    expect_result("m1_w1", 122, 0, 0);
    consume("m1_w1");
    for (int k = 64; k < 128; k++) send(100 * k);
    expect_result("m1_w2", 124, 0, 0);
    consume("m1_w2");

    // Wrapped delta: steps of +34 ending at 3200, then 3200 -> -3200 gives 34.
    do_clear(1'b1);
    p = 1058;
    for (int k = 0; k < 64; k++) begin
      send(p);
      p += 34;
      if (p > 3217) p -= 6434;
    end
    expect_result("wrap_w1", 41, 0, 0);
    consume("wrap_w1");
    check("wrap.next_phase", p, -3200);
    for (int k = 0; k < 64; k++) begin
      send(p);
      p += 34;
      if (p > 3217) p -= 6434;
    end
    expect_result("wrap_w2", 42, 0, 0);
    consume("wrap_w2");

    // Clear on sample 40 (that sample is dropped), back in mode 0.
    do_clear(1'b0);
    send_const(5000, 39);
    phase  = 19'(5000);
    sample = 1'b1;
    clear  = 1'b1;
    mode   = 1'b0;
    step();
    clear  = 1'b0;
    sample = 1'b0;
    mode   = 1'b1;
    send_const(1024, 64);
    expect_result("abort_clr", 1278, 0, 0);
    consume("abort_clr");

    // Reset between close and result: aborted window never shows up.
    send_const(2048, 64);
    step();
    mode = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("abort_rst.speed", $signed(speed), 0);
    check("abort_rst.valid", speed_valid, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    mode = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (speed_valid) saw_valid = 1'b1;
    end
    check("abort_rst.no_valid", saw_valid, 0);
    send_const(3072, 64);
    expect_result("after_rst", 3834, 0, 0);
    consume("after_rst");
    check("final.overrun_count", ovr_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
